// File: rtl/jt12_regwr.sv
// jt12_regwr: decodes CPU address/data writes into per-slot register-file update requests.
// Optional macro JT12_REGWR_QUEUE_EN adds a one-entry queue for data writes that arrive while busy.
module jt12_regwr #(
    parameter int num_ch = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_a,
    input  logic [7:0]  cpu_din,
    output logic        busy,
    output logic [7:0]  din,
    output logic [2:0]  ch,
    output logic [1:0]  op,
    output logic        up_keyon,
    output logic        up_dt1,
    output logic        up_tl,
    output logic        up_ks_ar,
    output logic        up_amen_dr,
    output logic        up_sr,
    output logic        up_sl_rr,
    output logic        up_ssgeg,
    output logic        up_fnumlo,
    output logic        up_alg,
    output logic        up_pms,
    output logic [5:0]  latch_fnum,
    output logic        effect,
    output logic        csm,
    output logic [10:0] fnum_ch3op1,
    output logic [10:0] fnum_ch3op2,
    output logic [10:0] fnum_ch3op3,
    output logic [2:0]  block_ch3op1,
    output logic [2:0]  block_ch3op2,
    output logic [2:0]  block_ch3op3
);
    localparam int HOLD = 4 * num_ch;
    localparam int N_UP = 11;
    localparam int UP_KEYON = 0, UP_DT1 = 1, UP_TL = 2, UP_KS_AR = 3, UP_AMEN_DR = 4, UP_SR = 5;
    localparam int UP_SL_RR = 6, UP_SSGEG = 7, UP_FNUMLO = 8, UP_ALG = 9, UP_PMS = 10;

    logic [7:0]      regaddr;
    logic            part;
    logic [4:0]      cnt;
    logic [N_UP-1:0] strobe;
    logic [5:0]      hi_latch;

    logic wr_addr, wr_data, tick_last;
    assign wr_addr   = cpu_wr & ~cpu_a[0];
    assign wr_data   = cpu_wr & cpu_a[0];
    assign busy      = (cnt != 5'd0);
    assign tick_last = clk_en && (cnt == 5'd1);

    // Decode source: the live write, or the queued entry at the release edge
    logic       dec_en;
    logic [7:0] dec_addr;
    logic [7:0] dec_data;
    logic       dec_part;

`ifdef JT12_REGWR_QUEUE_EN
    logic       q_valid;
    logic [7:0] q_addr;
    logic [7:0] q_data;
    logic       q_part;
    logic       q_take;

    assign q_take = wr_data & busy & ~q_valid & ~tick_last;

    // A write landing on the release edge with the queue empty is issued straight away
    always_comb begin
        dec_addr = regaddr;
        dec_part = part;
        dec_data = cpu_din;
        dec_en   = wr_data & ~busy;
        if (tick_last) begin
            if (q_valid) begin
                dec_addr = q_addr;
                dec_part = q_part;
                dec_data = q_data;
                dec_en   = 1'b1;
            end else begin
                dec_en = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_addr  <= '0;
            q_data  <= '0;
            q_part  <= 1'b0;
        end else if (tick_last && q_valid) begin
            q_valid <= 1'b0;
        end else if (q_take) begin
            q_valid <= 1'b1;
            q_addr  <= regaddr;
            q_data  <= cpu_din;
            q_part  <= part;
        end
    end
`else
    assign dec_addr = regaddr;
    assign dec_part = part;
    assign dec_data = cpu_din;
    assign dec_en   = wr_data & ~busy;
`endif

    logic            part_ok, lo_ok;
    logic [N_UP-1:0] dec_up;
    logic            dec_lfnum, dec_hi, dec_mode;
    logic [2:0]      dec_ch3;

    assign part_ok = !(dec_part && (num_ch == 3));
    assign lo_ok   = (dec_addr[1:0] != 2'd3);

    always_comb begin
        dec_up    = '0;
        dec_lfnum = 1'b0;
        dec_hi    = 1'b0;
        dec_mode  = 1'b0;
        dec_ch3   = '0;
        if (dec_en && part_ok) begin
            case (dec_addr[7:4])
                4'h2: if (!dec_part) begin
                    dec_up[UP_KEYON] = (dec_addr[3:0] == 4'h8);
                    dec_mode         = (dec_addr[3:0] == 4'h7);
                end
                4'h3: dec_up[UP_DT1]     = lo_ok;
                4'h4: dec_up[UP_TL]      = lo_ok;
                4'h5: dec_up[UP_KS_AR]   = lo_ok;
                4'h6: dec_up[UP_AMEN_DR] = lo_ok;
                4'h7: dec_up[UP_SR]      = lo_ok;
                4'h8: dec_up[UP_SL_RR]   = lo_ok;
                4'h9: dec_up[UP_SSGEG]   = lo_ok;
                4'hA: case (dec_addr[3:2])
                    2'd0: dec_up[UP_FNUMLO] = lo_ok;
                    2'd1: dec_lfnum         = lo_ok;
                    // A9 -> op1, AA -> op2, A8 -> op3
                    2'd2: if (!dec_part) begin
                        dec_ch3[0] = (dec_addr[1:0] == 2'd1);
                        dec_ch3[1] = (dec_addr[1:0] == 2'd2);
                        dec_ch3[2] = (dec_addr[1:0] == 2'd0);
                    end
                    default: dec_hi = lo_ok && !dec_part;
                endcase
                4'hB: begin
                    dec_up[UP_ALG] = lo_ok && (dec_addr[3:2] == 2'd0);
                    dec_up[UP_PMS] = lo_ok && (dec_addr[3:2] == 2'd1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regaddr      <= '0;
            part         <= 1'b0;
            cnt          <= '0;
            strobe       <= '0;
            din          <= '0;
            ch           <= '0;
            op           <= '0;
            hi_latch     <= '0;
            latch_fnum   <= '0;
            effect       <= 1'b0;
            csm          <= 1'b0;
            fnum_ch3op1  <= '0;
            fnum_ch3op2  <= '0;
            fnum_ch3op3  <= '0;
            block_ch3op1 <= '0;
            block_ch3op2 <= '0;
            block_ch3op3 <= '0;
        end else begin
            if (wr_addr) begin
                regaddr <= cpu_din;
                part    <= cpu_a[1];
            end
            if (|dec_up) begin
                strobe <= dec_up;
                din    <= dec_data;
                ch     <= {dec_part, dec_addr[1:0]};
                op     <= dec_addr[3:2];
                cnt    <= 5'(HOLD);
            end else if (busy && clk_en) begin
                cnt <= cnt - 5'd1;
                if (tick_last) strobe <= '0;
            end
            if (dec_lfnum) latch_fnum <= dec_data[5:0];
            if (dec_hi)    hi_latch   <= dec_data[5:0];
            if (dec_ch3[0]) begin
                fnum_ch3op1  <= {hi_latch[2:0], dec_data};
                block_ch3op1 <= hi_latch[5:3];
            end
            if (dec_ch3[1]) begin
                fnum_ch3op2  <= {hi_latch[2:0], dec_data};
                block_ch3op2 <= hi_latch[5:3];
            end
            if (dec_ch3[2]) begin
                fnum_ch3op3  <= {hi_latch[2:0], dec_data};
                block_ch3op3 <= hi_latch[5:3];
            end
            if (dec_mode) begin
                effect <= |dec_data[7:6];
                csm    <= (dec_data[7:6] == 2'b10);
            end
        end
    end

    assign up_keyon   = strobe[UP_KEYON];
    assign up_dt1     = strobe[UP_DT1];
    assign up_tl      = strobe[UP_TL];
    assign up_ks_ar   = strobe[UP_KS_AR];
    assign up_amen_dr = strobe[UP_AMEN_DR];
    assign up_sr      = strobe[UP_SR];
    assign up_sl_rr   = strobe[UP_SL_RR];
    assign up_ssgeg   = strobe[UP_SSGEG];
    assign up_fnumlo  = strobe[UP_FNUMLO];
    assign up_alg     = strobe[UP_ALG];
    assign up_pms     = strobe[UP_PMS];
endmodule
